// File: rtl/p2s_pkg.sv
`default_nettype none
// ============================================================================
// p2s_pkg : shared state type and frame constants for p2s_serializer
// Rev 1.0
// ============================================================================
package p2s_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WORDS     = 8;
    localparam int CNT_W     = 3;
    localparam int LAST_BEAT = 7;

endpackage
`default_nettype wire

// File: rtl/p2s_beat_counter.sv
`default_nettype none
// ============================================================================
// p2s_beat_counter : 3-bit beat index with synchronous clear, enable and wrap
// Rev 1.0
// ============================================================================
module p2s_beat_counter
    import p2s_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(LAST_BEAT);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment so a load on the final beat restarts at 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= (r_cnt == c_last_beat) ? '0 : r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == c_last_beat);

endmodule
`default_nettype wire

// File: rtl/p2s_serializer.sv
`default_nettype none
// ============================================================================
// p2s_serializer : 8-word parallel frame to valid/ready word stream, x8 first.
// Optional macro P2S_BACK_TO_BACK_EN allows a load on the last beat.
// Rev 1.0
// ============================================================================
module p2s_serializer
    import p2s_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [2**N-1:0]   x1,
    input  logic [2**N-1:0]   x2,
    input  logic [2**N-1:0]   x3,
    input  logic [2**N-1:0]   x4,
    input  logic [2**N-1:0]   x5,
    input  logic [2**N-1:0]   x6,
    input  logic [2**N-1:0]   x7,
    input  logic [2**N-1:0]   x8,
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              y_last,
    output logic              busy
);

    localparam int               W           = 2**N;
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(LAST_BEAT);

    state_t           r_state;
    logic [W-1:0]     r_shadow [WORDS];
    logic [W-1:0]     w_x      [WORDS];
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_sel;
    logic             w_last;
    logic             w_xfer;
    logic             w_load;

    assign w_x[0] = x1;
    assign w_x[1] = x2;
    assign w_x[2] = x3;
    assign w_x[3] = x4;
    assign w_x[4] = x5;
    assign w_x[5] = x6;
    assign w_x[6] = x7;
    assign w_x[7] = x8;

    assign w_xfer = (r_state == SHIFT) && y_ready;

`ifdef P2S_BACK_TO_BACK_EN
    assign load_ready = !rst && ((r_state == IDLE) || (w_last && w_xfer));
`else
    assign load_ready = !rst && (r_state == IDLE);
`endif

    assign w_load = load_valid && load_ready;

    p2s_beat_counter u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_load),
        .inc  (w_xfer),
        .cnt  (w_cnt),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            for (int i = 0; i < WORDS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_state <= SHIFT;
                for (int i = 0; i < WORDS; i++) begin
                    r_shadow[i] <= w_x[i];
                end
            end else if (w_xfer && w_last) begin
                r_state <= IDLE;
            end
        end
    end

    // Beat 0 carries x8 (shadow index 7) so a downstream shifter ends with x1 in y1.
    assign w_sel   = c_last_beat - w_cnt;
    assign y       = r_shadow[w_sel];
    assign y_valid = (r_state == SHIFT);
    assign y_last  = (r_state == SHIFT) && w_last;
    assign busy    = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_p2s_serializer.sv
`default_nettype none
// ============================================================================
// tb_p2s_serializer : scoreboard bench with serial-to-parallel loopback model
// Rev 1.0
// ============================================================================
module tb_p2s_serializer;
    import p2s_pkg::*;

    localparam int N = 4;
    localparam int W = 2**N;

`ifdef P2S_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         load_valid = 1'b0;
    logic         y_ready    = 1'b0;
    logic [W-1:0] xv [1:8];
    logic         load_ready;
    logic         y_valid;
    logic         y_last;
    logic         busy;
    logic [W-1:0] y;

    p2s_serializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .x1         (xv[1]),
        .x2         (xv[2]),
        .x3         (xv[3]),
        .x4         (xv[4]),
        .x5         (xv[5]),
        .x6         (xv[6]),
        .x7         (xv[7]),
        .x8         (xv[8]),
        .y          (y),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_last     (y_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: {last, word} per beat, plus whole frames for the loopback shifter.
    logic [W:0]     exp_q   [$];
    logic [8*W-1:0] frame_q [$];
    int             first_q [$];
    int             last_q  [$];

    int             cyc = 0;
    int             beat_idx = 0;
    bit             first_seen = 1'b0;
    bit             stalled = 1'b0;
    bit             rand_rdy = 1'b0;
    logic [W-1:0]   hold_y;
    logic           hold_last;
    logic [W-1:0]   sp [1:8];
    logic [W:0]     e;
    logic [8*W-1:0] f;
    int             acc_cycle;
    logic           acc_valid;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            beat_idx   = 0;
            first_seen = 1'b0;
            stalled    = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", {31'd0, y_valid}, 32'd1);
                check("stall_y", {16'd0, y}, {16'd0, hold_y});
                check("stall_last", {31'd0, y_last}, {31'd0, hold_last});
            end
            stalled = 1'b0;
            if (y_valid && !first_seen) begin
                first_seen = 1'b1;
                first_q.push_back(cyc);
            end
            if (y_valid && !y_ready) begin
                stalled   = 1'b1;
                hold_y    = y;
                hold_last = y_last;
            end
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_y", {16'd0, y}, {16'd0, e[W-1:0]});
                    check("beat_last", {31'd0, y_last}, {31'd0, e[W]});
                end
                for (int i = 8; i > 1; i--) sp[i] = sp[i-1];
                sp[1] = y;
                beat_idx++;
                if (beat_idx == 8) begin
                    beat_idx   = 0;
                    first_seen = 1'b0;
                    last_q.push_back(cyc);
                    if (frame_q.size() != 0) begin
                        f = frame_q.pop_front();
                        for (int i = 1; i <= 8; i++)
                            check("loopback", {16'd0, sp[i]}, {16'd0, f[(i-1)*W +: W]});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) y_ready = ($urandom_range(3) != 0);
    endtask

    function automatic logic [8*W-1:0] seq_frame(input logic [W-1:0] base);
        logic [8*W-1:0] r;
        for (int i = 1; i <= 8; i++) r[(i-1)*W +: W] = base + W'(i - 1);
        return r;
    endfunction

    task automatic do_reset(input int n);
        rst        = 1'b1;
        load_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_load_ready", {31'd0, load_ready}, 32'd0);
            tick();
        end
        @(negedge clk);
        check("rst_y_valid", {31'd0, y_valid}, 32'd0);
        check("rst_y_last", {31'd0, y_last}, 32'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        frame_q.delete();
        @(negedge clk);
        check("post_rst_y", {16'd0, y}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_y_valid", {31'd0, y_valid}, 32'd0);
        check("post_rst_load_ready", {31'd0, load_ready}, 32'd1);
        tick();
    endtask

    task automatic load_frame(input logic [8*W-1:0] fr);
        int waited = 0;
        for (int i = 1; i <= 8; i++) xv[i] = fr[(i-1)*W +: W];
        load_valid = 1'b1;
        @(negedge clk);
        while (!load_ready && waited < 200) begin
            tick();
            @(negedge clk);
            waited++;
        end
        check("load_accept", {31'd0, load_ready}, 32'd1);
        if (load_ready) begin
            acc_cycle = cyc;
            acc_valid = y_valid;
            for (int i = 8; i >= 1; i--) exp_q.push_back({(i == 1), fr[(i-1)*W +: W]});
            frame_q.push_back(fr);
        end
        tick();
        load_valid = 1'b0;
        // Scramble inputs so any post-load capture shows up as a data error.
        for (int i = 1; i <= 8; i++) xv[i] = W'($urandom);
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((exp_q.size() != 0 || y_valid) && waited < 400) begin
            tick();
            waited++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_beats(input int n);
        int waited = 0;
        while (beat_idx != n && waited < 50) begin
            tick();
            waited++;
        end
        check("wait_beats", 32'(beat_idx), 32'(n));
    endtask

    initial begin
        logic [13:0] pat;
        for (int i = 1; i <= 8; i++) xv[i] = '0;
        for (int i = 1; i <= 8; i++) sp[i] = '0;

        do_reset(2);

        // Single frame, continuous ready.
        y_ready = 1'b1;
        first_q.delete();
        last_q.delete();
        load_frame(seq_frame(16'h0001));
        wait_drain();
        check("first_latency", 32'(first_q[0] - acc_cycle), 32'd1);
        check("frame_span", 32'(last_q[0] - first_q[0]), 32'd7);
        @(negedge clk);
        check("idle_load_ready", {31'd0, load_ready}, 32'd1);
        tick();

        // Backpressure on beats 2 and 5, three cycles each.
        first_q.delete();
        last_q.delete();
        load_frame(seq_frame(16'h0101));
        pat = 14'b1000_1110_0011_11;
        for (int i = 0; i < 14; i++) begin
            y_ready = pat[13-i];
            tick();
        end
        y_ready = 1'b1;
        wait_drain();
        check("stall_span", 32'(last_q[0] - first_q[0]), 32'd13);

        // Load offered mid-frame.
        load_frame(seq_frame(16'h1000));
        wait_beats(2);
        check("busy_load_ready", {31'd0, load_ready}, 32'd0);
        load_frame(seq_frame(16'h2000));
        check("accept_point_valid", {31'd0, acc_valid}, {31'd0, B2B});
        wait_drain();

        // Reset mid-frame, then a fresh frame.
        load_frame(seq_frame(16'hC000));
        wait_beats(3);
        do_reset(1);
        load_frame(seq_frame(16'hA5A5));
        wait_drain();

        // Two frames offered back to back.
        first_q.delete();
        last_q.delete();
        load_frame(seq_frame(16'h3000));
        load_frame(seq_frame(16'h4000));
        wait_drain();
        check("b2b_gap", 32'(first_q[1] - last_q[0]), B2B ? 32'd1 : 32'd2);
        check("b2b_span", 32'(last_q[1] - first_q[0]), B2B ? 32'd15 : 32'd16);

        // Random loopback frames with random backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            load_frame({$urandom, $urandom, $urandom, $urandom});
        end
        wait_drain();
        rand_rdy = 1'b0;
        y_ready  = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/p2s_serializer.md
Name: p2s_serializer

Overview:
- Parallel-to-serial converter; the transmit-side counterpart of the serial-to-parallel word shifter.
- Accepts one frame of 8 words, each 2**N bits wide, in a single load handshake.
- Emits the frame one word per accepted beat on a valid/ready stream.
- Word order is chosen so that a downstream 8-stage serial-to-parallel shifter, fed this stream, reproduces x1..x8 on its y1..y8 outputs.

Parameters:
- N, 4, word width exponent; word width W = 2**N bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  frame x1..x8 is valid.
- load_ready  output  1  block can accept a frame.
- x1..x8  input  W each  parallel frame words; x1 is the MSB word, x8 the LSB word.
- y  output  W  serial output word.
- y_valid  output  1  y holds a valid beat.
- y_ready  input  1  downstream accepts the beat.
- y_last  output  1  current beat is the final word of the frame (x1).
- busy  output  1  a frame is being shifted out.

Behaviour:
- Reset: all state is cleared on rising clk with rst=1.
  - state=IDLE, beat counter=0, shadow registers=0.
  - y=0, y_valid=0, y_last=0, busy=0.
  - load_ready=0 while rst=1.
- States:
  - IDLE: load_ready=1, y_valid=0.
  - SHIFT: y_valid=1, busy=1.
- IDLE -> SHIFT on load_valid & load_ready:
  - x1..x8 are captured into 8 shadow registers; cnt=0.
  - First beat appears on y the cycle after acceptance (latency 1).
- Emission order (cnt 0..7): x8, x7, x6, x5, x4, x3, x2, x1.
  - y is a mux of the shadow registers selected by cnt.
  - y_last = (cnt==7).
- Beat transfer happens on y_valid & y_ready.
  - On transfer, cnt increments.
  - On transfer with cnt==7: cnt wraps to 0 and state returns to IDLE.
- y_ready=0 stalls: y, y_last and cnt hold; y_valid stays 1 (no retraction).
- Input changes:
  - x1..x8 changing while in SHIFT has no effect; the shadow registers are written only on load acceptance.
  - load_valid while not load_ready is ignored; the producer must hold it until accepted.
- Reset mid-frame: the remaining beats are discarded, no partial y_last is issued, and the block is in IDLE on the cycle after rst deasserts.
- Throughput:
  - Base build: 8 beats per 9 cycles with continuous y_ready (one IDLE bubble between frames).
- No combinational path from load_valid to y.
- load_ready depends only on state and rst. In the optional build it also depends on y_ready.

Optional Feature:
- Macro: P2S_BACK_TO_BACK_EN
- Defined:
  - load_ready is also 1 in SHIFT when cnt==7 & y_ready.
  - A load accepted on the last beat overwrites the shadow registers and sets cnt=0 while remaining in SHIFT.
  - Result is zero-bubble streaming: 8 beats per 8 cycles.
- Undefined:
  - load_ready is 1 only in IDLE (base behaviour above).

Decomposition:
- Package p2s_pkg holds:
  - state enum {IDLE, SHIFT}
  - constant WORDS=8
  - constant CNT_W=3
  - last-beat index constant LAST_BEAT=7
- One sub-module, p2s_beat_counter:
  - 3-bit counter with synchronous clear, increment enable and wrap.
  - Outputs cnt and last (cnt==7).
- Shadow register bank and output mux stay in the top level.

Test Plan:
- Reset then frame: rst 2 cycles; load x1..x8=16'h0001..16'h0008, y_ready=1 -> y = 0008,0007,...,0001 on 8 consecutive cycles starting 1 cycle after acceptance; y_last=1 only with 0001; then load_ready=1.
- Backpressure: y_ready=0 on beats 2 and 5 for 3 cycles each -> y, y_last and cnt held, y_valid stays 1; full sequence intact; 14 cycles from first beat to last beat.
- Load during SHIFT: drive load_valid=1 with new x values at beat 3 -> ignored (load_ready=0 in base build); original frame completes unchanged; new frame accepted in the IDLE cycle.
- Reset mid-frame: rst at beat 4 -> y_valid=0 the next cycle, no y_last; the following load of 16'hA5A5..16'hA5AC streams correctly from the first word.
- Loopback: p2s output into an 8-stage serial-to-parallel shifter enabled on y_valid & y_ready -> after 8 beats the shifter's y1..y8 equal x1..x8 (random values, 100 frames).
- P2S_BACK_TO_BACK_EN: two frames offered back-to-back with y_ready=1 -> 16 beats on 16 consecutive cycles, y_last on beats 8 and 16; without the macro, one y_valid=0 cycle between the two frames.
